reaction_ctrl: RTL
==================

# reaction_ctrl

Control stage for the reaction-time tester, directly upstream of the decimal digit-counter chain. It sequences a test: arm on a start press, wait a pseudo-random delay, light the GO LED, then time the user in 1 ms ticks. It drives the `det_start`, `trig` and `flow` inputs of the least-significant digit counter, and watches the most-significant digit's `carry` to detect overflow.

## Interface
- `CLK_FREQ`, default 50_000_000: clock frequency in Hz.
- `TICK_HZ`, default 1000: timing resolution. `DIV = CLK_FREQ/TICK_HZ`, which must be ≥ 2.
- `DELAY_MIN`, default 1000: minimum random wait, in ticks.
- `DELAY_MASK`, default 16'h07FF: mask applied to the LFSR to form the random extra wait, in ticks.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start_btn` in 1: debounced, single-cycle pulse; starts or restarts a test.
- `react_btn` in 1: debounced, single-cycle pulse; the user's reaction press.
- `carry_in` in 1: carry output of the most-significant digit counter.
- `det_start` out 1: one-cycle clear to the digit counters.
- `trig` out 1: one-cycle count pulse to the LS digit.
- `flow` out 1: one-cycle overflow/foul pulse; forces the digits to the dash code.
- `led_go` out 1: GO stimulus LED.
- `busy` out 1: high in ARM, WAIT and RUN.
- `foul` out 1: high in FOUL.

## Operation
- All outputs reset to 0. After reset the FSM is in IDLE, the LFSR equals 16'hACE1 and the prescaler is 0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11+1.
  - Advances every clock in every state and never holds 0.
- Prescaler:
  - Counts 0..DIV-1 and wraps.
  - Internal `tick` is high in the cycle the count equals DIV-1.
  - Forced to 0 in ARM.
- Wait counter: 16 bits. Loaded in ARM with `DELAY_MIN + (lfsr & DELAY_MASK)`. Decrements on each `tick` in WAIT. Saturates at 0.
- FSM states:
  - IDLE: on `start_btn`, go to ARM.
  - ARM (1 cycle): `det_start`=1, load the wait counter, clear the prescaler. Go to WAIT.
  - WAIT:
    - On `react_btn`, go to FOUL (false start).
    - Otherwise, on `tick` with wait counter == 1, go to RUN.
  - RUN: `led_go`=1. Each `tick` produces `trig`. Exits, in priority order:
    - `carry_in` goes to OVER.
    - `react_btn` goes to DONE.
  - DONE: hold. The counters keep the reaction time.
  - OVER / FOUL: assert `flow` for exactly the entry cycle, then hold.
  - From DONE, OVER or FOUL, `start_btn` goes to ARM.
- `start_btn` is ignored in ARM, WAIT and RUN; a test cannot be restarted mid-run. `react_btn` is ignored in IDLE, DONE, OVER and FOUL.
- Simultaneous events in RUN:
  - `react_btn` and `tick` in the same cycle: DONE is taken and the `trig` for that tick is suppressed. The count excludes the partial tick.
  - `carry_in` and `react_btn` in the same cycle: OVER wins.
- Reset mid-operation returns to IDLE immediately (asynchronous). All outputs go to 0, including `led_go`.

## Timing
- `det_start`, `trig`, `flow`, `led_go`, `busy` and `foul` are registered, with no combinational input-to-output path.
- `start_btn` at cycle N (in IDLE): ARM at N+1, `det_start` high in cycle N+1, WAIT from N+2.
- The first WAIT tick occurs DIV cycles after the prescaler clear. RUN is entered with `led_go` rising in the cycle after the D-th tick, where D is the loaded delay.
- `trig` is high for 1 cycle, in the cycle after each internal `tick` while in RUN. Spacing between `trig` pulses is exactly DIV cycles.
- `react_btn` at cycle M (in RUN): `led_go` low from M+1. No `trig` at or after M+1.
- `flow` is high exactly 1 cycle, in the cycle the FSM enters OVER or FOUL.
- `carry_in` arrives 1 cycle after the `trig` that wraps the MS digit. The controller reacts in the next cycle, which is early enough that no further `trig` is issued when DIV ≥ 3.

## Test plan
Bench parameters: CLK_FREQ=1000, TICK_HZ=100 (DIV=10), DELAY_MIN=3, DELAY_MASK=16'h0003.
- Reset values: assert `rst_n`=0 mid-RUN → all outputs 0 within the same cycle; FSM in IDLE; the next `start_btn` pulse produces `det_start` one cycle later.
- Nominal run: `start_btn`, then `react_btn` 47 cycles after `led_go` rises → exactly 4 `trig` pulses, 10 cycles apart; `led_go` falls next cycle; `flow` never asserted.
- Random delay range: 64 back-to-back tests → every WAIT length is within 3..6 ticks (30..60 cycles ±1); at least 3 distinct lengths are observed.
- False start: `react_btn` during WAIT → `flow` high 1 cycle; `foul`=1; `led_go` never rises; `trig` stays 0.
- Overflow: in RUN, pulse `carry_in` → `flow` 1 cycle; no further `trig`; `busy`=0; then `start_btn` → `det_start` and a new test begins.
- Collisions: `react_btn` in the same cycle as `tick` → no `trig` follows. `react_btn` together with `carry_in` → OVER (`flow` pulses). `start_btn` during RUN → ignored; `trig` continues.

Source files
------------

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: sequencer for the reaction-time tester.
// Arms on a start press, waits a pseudo-random number of ticks, lights the
// GO LED, then emits one count pulse per tick to the digit-counter chain
// until the user reacts or the most-significant digit carries out.
module reaction_ctrl #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned TICK_HZ    = 1000,
  parameter int unsigned DELAY_MIN  = 1000,
  parameter logic [15:0] DELAY_MASK = 16'h07FF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_btn,
  input  logic react_btn,
  input  logic carry_in,
  output logic det_start,
  output logic trig,
  output logic flow,
  output logic led_go,
  output logic busy,
  output logic foul
);

  localparam int unsigned     DIV        = CLK_FREQ / TICK_HZ;
  localparam int unsigned     PW         = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(DIV - 1);
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
  // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_RUN,
    S_DONE,
    S_OVER,
    S_FOUL
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic [15:0]   wait_cnt;
  logic          tick;

  assign tick = (presc == PRESC_MAX);

  // Free-running LFSR; a non-zero seed on a maximal polynomial never reaches 0.
  // NOTE: every clocked block uses non-blocking (<=) so all registers sample
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // Tick prescaler; restarted in ARM so the first wait tick is exactly DIV cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (state == S_ARM || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Random wait length, sampled from the LFSR in ARM and counted down in ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == S_ARM) begin
      wait_cnt <= 16'(DELAY_MIN) + (lfsr & DELAY_MASK);
    end else if (state == S_WAIT && tick && wait_cnt != 16'd0) begin
      wait_cnt <= wait_cnt - 16'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; carry_in outranks react_btn in RUN.
  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start_btn) next_state = S_ARM;
      S_ARM:  next_state = S_WAIT;
      S_WAIT: begin
        if (react_btn)                          next_state = S_FOUL;
        else if (tick && wait_cnt == 16'd1)     next_state = S_RUN;
      end
      S_RUN: begin
        if (carry_in)       next_state = S_OVER;
        else if (react_btn) next_state = S_DONE;
      end
      S_DONE, S_OVER, S_FOUL: if (start_btn) next_state = S_ARM;
      default: next_state = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state, so each output
  // lines up with the cycle the FSM sits in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_start <= 1'b0;
      trig      <= 1'b0;
      flow      <= 1'b0;
      led_go    <= 1'b0;
      busy      <= 1'b0;
      foul      <= 1'b0;
    end else begin
      det_start <= (next_state == S_ARM);
      // A tick that coincides with an exit is a partial tick and is not counted.
      trig      <= (state == S_RUN) && tick && (next_state == S_RUN);
      flow      <= (next_state == S_OVER || next_state == S_FOUL) && (next_state != state);
      led_go    <= (next_state == S_RUN);
      busy      <= (next_state == S_ARM || next_state == S_WAIT || next_state == S_RUN);
      foul      <= (next_state == S_FOUL);
    end
  end

endmodule
